// File: rtl/segre_mem_stage.sv
// segre_mem_stage: EX/MEM register, data-memory handshake, load/store alignment.
// Optional: SEGRE_MEM_MISALIGN_CHECK_EN traps misaligned HALF/WORD accesses.

package segre_pkg;
    localparam int WORD_SIZE = 32;
    localparam int ADDR_SIZE = 32;
    localparam int REG_SIZE  = 5;

    typedef enum logic [1:0] {
        BYTE,
        HALF,
        WORD
    } memop_data_type_e;
endpackage

module segre_mem_stage
    import segre_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_ex_i,
    input  logic                 finish_test_i,
    input  logic [WORD_SIZE-1:0] alu_res_i,
    input  logic                 rf_we_i,
    input  logic [REG_SIZE-1:0]  rf_waddr_i,
    input  logic [WORD_SIZE-1:0] rf_st_data_i,
    input  memop_data_type_e     memop_type_i,
    input  logic                 memop_rd_i,
    input  logic                 memop_wr_i,
    input  logic                 memop_sign_ext_i,
    input  logic [ADDR_SIZE-1:0] seq_new_pc_i,
    input  logic                 is_jaljalr_i,
    input  logic                 block_mem_i,
    input  logic                 inject_nops_i,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [ADDR_SIZE-1:0] mem_addr_o,
    output logic [3:0]           mem_be_o,
    output logic [WORD_SIZE-1:0] mem_wdata_o,
    input  logic                 mem_rvalid_i,
    input  logic [WORD_SIZE-1:0] mem_rdata_i,
    output logic                 rf_we_o,
    output logic [REG_SIZE-1:0]  rf_waddr_o,
    output logic [WORD_SIZE-1:0] rf_wdata_o,
    output logic                 valid_mem_o,
    output logic                 finish_test_o,
    output logic                 stall_mem_o,
    output logic                 misaligned_o
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_e;

    state_e state_q;

    logic                 valid_q;
    logic                 finish_test_q;
    logic                 rf_we_q;
    logic                 memop_rd_q;
    logic                 memop_wr_q;
    logic                 is_jaljalr_q;
    logic                 done_q;
    logic [WORD_SIZE-1:0] alu_res_q;
    logic [REG_SIZE-1:0]  rf_waddr_q;
    logic [WORD_SIZE-1:0] rf_st_data_q;
    memop_data_type_e     memop_type_q;
    logic                 memop_sign_ext_q;
    logic [ADDR_SIZE-1:0] seq_new_pc_q;

    logic                 hold;
    logic                 memop;
    logic                 mis;
    logic                 in_wait;
    logic [1:0]           off;
    logic [4:0]           shamt;
    logic [WORD_SIZE-1:0] lane_w;
    logic [15:0]          lane_h;
    logic [WORD_SIZE-1:0] ld_data;
    logic [3:0]           be;
    logic [WORD_SIZE-1:0] wdata;

    assign off     = alu_res_q[1:0];
    assign shamt   = {off, 3'b000};
    assign in_wait = (state_q == WAIT);

    // done_q marks an access that already completed while the register
    // is frozen by block_mem_i, so it is neither re-issued nor re-presented.
`ifdef SEGRE_MEM_MISALIGN_CHECK_EN
    assign mis = valid_q & ~done_q & (memop_rd_q | memop_wr_q)
               & (((memop_type_q == HALF) & off[0])
               | ((memop_type_q == WORD) & (off != 2'b00)));
`else
    assign mis = 1'b0;
`endif

    assign memop = valid_q & ~done_q & (memop_rd_q | memop_wr_q) & ~mis;

    assign stall_mem_o = ((state_q == IDLE) & memop)
                       | (in_wait & ~mem_rvalid_i);
    assign hold        = block_mem_i | stall_mem_o;

    assign mem_req_o    = (state_q == IDLE) & memop;
    assign mem_we_o     = memop_wr_q;
    assign mem_addr_o   = {alu_res_q[ADDR_SIZE-1:2], 2'b00};
    assign mem_be_o     = be;
    assign mem_wdata_o  = wdata;
    assign misaligned_o = mis;

    assign valid_mem_o   = valid_q & ~done_q
                         & (~memop | (in_wait & mem_rvalid_i));
    assign rf_we_o       = rf_we_q & valid_mem_o & ~mis;
    assign finish_test_o = finish_test_q & valid_mem_o;
    assign rf_waddr_o    = rf_waddr_q;

    // Byte enables and lane-replicated store data.
    always_comb begin
        be    = 4'b1111;
        wdata = rf_st_data_q;
        case (memop_type_q)
            BYTE: begin
                be    = 4'b0001 << off;
                wdata = {4{rf_st_data_q[7:0]}};
            end
            HALF: begin
                be    = 4'b0011 << {off[1], 1'b0};
                wdata = {2{rf_st_data_q[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = rf_st_data_q;
            end
        endcase
    end

    // Load lane extraction with sign/zero extension.
    always_comb begin
        lane_w  = mem_rdata_i >> shamt;
        lane_h  = off[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        ld_data = mem_rdata_i;
        case (memop_type_q)
            BYTE: ld_data = {{24{memop_sign_ext_q & lane_w[7]}},
                             lane_w[7:0]};
            HALF: ld_data = {{16{memop_sign_ext_q & lane_h[15]}},
                             lane_h};
            default: ld_data = mem_rdata_i;
        endcase
    end

    // Write-back value select.
    always_comb begin
        rf_wdata_o = alu_res_q;
        if (memop_rd_q)
            rf_wdata_o = ld_data;
        else if (is_jaljalr_q)
            rf_wdata_o = seq_new_pc_q;
    end

    // Request/response FSM.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: if (memop) state_q <= WAIT;
                WAIT: if (mem_rvalid_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Completed-while-blocked flag, cleared when a new instruction enters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            done_q <= 1'b0;
        else if (!hold)
            done_q <= 1'b0;
        else if (in_wait && mem_rvalid_i)
            done_q <= 1'b1;
    end

    // Control half of the EX/MEM register; bubbles clear these bits.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q       <= 1'b0;
            finish_test_q <= 1'b0;
            rf_we_q       <= 1'b0;
            memop_rd_q    <= 1'b0;
            memop_wr_q    <= 1'b0;
            is_jaljalr_q  <= 1'b0;
        end else if (!hold) begin
            valid_q       <= valid_ex_i & ~inject_nops_i;
            finish_test_q <= finish_test_i & ~inject_nops_i;
            rf_we_q       <= rf_we_i & ~inject_nops_i;
            memop_rd_q    <= memop_rd_i & ~inject_nops_i;
            memop_wr_q    <= memop_wr_i & ~inject_nops_i;
            is_jaljalr_q  <= is_jaljalr_i & ~inject_nops_i;
        end
    end

    // Data half of the EX/MEM register.
    always_ff @(posedge clk_i) begin
        if (!hold) begin
            alu_res_q        <= alu_res_i;
            rf_waddr_q       <= rf_waddr_i;
            rf_st_data_q     <= rf_st_data_i;
            memop_type_q     <= memop_type_i;
            memop_sign_ext_q <= memop_sign_ext_i;
            seq_new_pc_q     <= seq_new_pc_i;
        end
    end

endmodule

// File: tb/tb_segre_mem_stage.sv
// tb_segre_mem_stage: directed and random checks of segre_mem_stage
// against an arithmetic reference model of the access rules.

module tb_segre_mem_stage;
    import segre_pkg::*;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             valid_ex_i;
    logic             finish_test_i;
    logic [31:0]      alu_res_i;
    logic             rf_we_i;
    logic [4:0]       rf_waddr_i;
    logic [31:0]      rf_st_data_i;
    memop_data_type_e memop_type_i;
    logic             memop_rd_i;
    logic             memop_wr_i;
    logic             memop_sign_ext_i;
    logic [31:0]      seq_new_pc_i;
    logic             is_jaljalr_i;
    logic             block_mem_i;
    logic             inject_nops_i;
    logic             mem_req_o;
    logic             mem_we_o;
    logic [31:0]      mem_addr_o;
    logic [3:0]       mem_be_o;
    logic [31:0]      mem_wdata_o;
    logic             mem_rvalid_i;
    logic [31:0]      mem_rdata_i;
    logic             rf_we_o;
    logic [4:0]       rf_waddr_o;
    logic [31:0]      rf_wdata_o;
    logic             valid_mem_o;
    logic             finish_test_o;
    logic             stall_mem_o;
    logic             misaligned_o;

    int total = 0;
    int bad   = 0;

    segre_mem_stage dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .valid_ex_i(valid_ex_i), .finish_test_i(finish_test_i),
        .alu_res_i(alu_res_i), .rf_we_i(rf_we_i),
        .rf_waddr_i(rf_waddr_i), .rf_st_data_i(rf_st_data_i),
        .memop_type_i(memop_type_i), .memop_rd_i(memop_rd_i),
        .memop_wr_i(memop_wr_i), .memop_sign_ext_i(memop_sign_ext_i),
        .seq_new_pc_i(seq_new_pc_i), .is_jaljalr_i(is_jaljalr_i),
        .block_mem_i(block_mem_i), .inject_nops_i(inject_nops_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .rf_we_o(rf_we_o),
        .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .valid_mem_o(valid_mem_o), .finish_test_o(finish_test_o),
        .stall_mem_o(stall_mem_o), .misaligned_o(misaligned_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] m_be(input int t, input int off);
        if (t == 0) return 4'(1 << off);
        if (t == 1) return (off >= 2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wd(input int t, input logic [31:0] d);
        if (t == 0) return (d & 32'hFF) * 32'h0101_0101;
        if (t == 1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_ld(input int t, input int off,
                                         input bit se, input logic [31:0] r);
        logic [31:0] v;
        if (t == 0) begin
            v = (r >> (8 * off)) & 32'hFF;
            if (se && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else if (t == 1) begin
            v = (r >> (16 * (off / 2))) & 32'hFFFF;
            if (se && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end else begin
            v = r;
        end
        return v;
    endfunction

    function automatic bit m_mis(input int t, input int off);
`ifdef SEGRE_MEM_MISALIGN_CHECK_EN
        return (t == 1 && (off % 2) == 1) || (t == 2 && off != 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input int kind, input logic [31:0] a, input int t,
                         input bit se, input logic [31:0] sd,
                         input logic [4:0] wa, input logic [31:0] pc,
                         input bit ft);
        valid_ex_i       = 1'b1;
        finish_test_i    = ft;
        alu_res_i        = a;
        rf_we_i          = (kind != 3);
        rf_waddr_i       = wa;
        rf_st_data_i     = sd;
        memop_type_i     = memop_data_type_e'(t);
        memop_rd_i       = (kind == 2);
        memop_wr_i       = (kind == 3);
        memop_sign_ext_i = se;
        seq_new_pc_i     = pc;
        is_jaljalr_i     = (kind == 1);
    endtask

    // kind: 0 ALU, 1 JAL, 2 load, 3 store
    task automatic run(input int kind, input logic [31:0] a, input int t,
                       input bit se, input logic [31:0] sd,
                       input logic [4:0] wa, input logic [31:0] pc,
                       input int lat, input logic [31:0] rd);
        int off;
        int stalls;
        bit mis;
        bit ft;
        off = int'(a & 32'h3);
        ft  = 1'($urandom_range(0, 1));
        mis = (kind >= 2) && m_mis(t, off);
        step();
        drive(kind, a, t, se, sd, wa, pc, ft);
        step();
        valid_ex_i = 1'b0;
        #1;
        if (kind < 2 || mis) begin
            chk("nm_valid", 32'(valid_mem_o), 32'd1);
            chk("nm_stall", 32'(stall_mem_o), 32'd0);
            chk("nm_req", 32'(mem_req_o), 32'd0);
            chk("nm_we", 32'(rf_we_o), mis ? 32'd0 : 32'd1);
            chk("nm_mis", 32'(misaligned_o), 32'(mis));
            chk("nm_fin", 32'(finish_test_o), 32'(ft));
            chk("nm_waddr", 32'(rf_waddr_o), 32'(wa));
            if (kind < 2)
                chk("nm_wdata", rf_wdata_o, (kind == 1) ? pc : a);
            return;
        end
        chk("req", 32'(mem_req_o), 32'd1);
        chk("req_stall", 32'(stall_mem_o), 32'd1);
        chk("req_valid", 32'(valid_mem_o), 32'd0);
        chk("addr", mem_addr_o, a & 32'hFFFF_FFFC);
        chk("be", 32'(mem_be_o), 32'(m_be(t, off)));
        chk("mwe", 32'(mem_we_o), 32'(kind == 3));
        if (kind == 3) chk("wdata", mem_wdata_o, m_wd(t, sd));
        stalls = 1;
        for (int k = 1; k < lat; k++) begin
            step();
            chk("wait_req", 32'(mem_req_o), 32'd0);
            chk("wait_valid", 32'(valid_mem_o), 32'd0);
            chk("wait_addr", mem_addr_o, a & 32'hFFFF_FFFC);
            if (stall_mem_o) stalls++;
        end
        step();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rd;
        #1;
        chk("ack_valid", 32'(valid_mem_o), 32'd1);
        chk("ack_stall", 32'(stall_mem_o), 32'd0);
        chk("ack_we", 32'(rf_we_o), 32'(kind == 2));
        chk("ack_fin", 32'(finish_test_o), 32'(ft));
        chk("stall_cycles", 32'(stalls), 32'(lat));
        if (kind == 2) chk("ld_data", rf_wdata_o, m_ld(t, off, se, rd));
        step();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = $urandom;
        #1;
        chk("after_valid", 32'(valid_mem_o), 32'd0);
        chk("after_req", 32'(mem_req_o), 32'd0);
    endtask

    initial begin
        rst_i = 1'b1;
        valid_ex_i = 0; finish_test_i = 0; alu_res_i = 0; rf_we_i = 0;
        rf_waddr_i = 0; rf_st_data_i = 0; memop_type_i = BYTE;
        memop_rd_i = 0; memop_wr_i = 0; memop_sign_ext_i = 0;
        seq_new_pc_i = 0; is_jaljalr_i = 0; block_mem_i = 0;
        inject_nops_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
        #12;
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_stall", 32'(stall_mem_o), 32'd0);
        chk("rst_valid", 32'(valid_mem_o), 32'd0);
        chk("rst_we", 32'(rf_we_o), 32'd0);
        chk("rst_fin", 32'(finish_test_o), 32'd0);
        chk("rst_mis", 32'(misaligned_o), 32'd0);
        step();
        rst_i = 1'b0;

        run(0, 32'h0000_1234, 2, 0, 0, 5'd5, 0, 1, 0);
        run(2, 32'h0000_0103, 0, 1, 0, 5'd6, 0, 3, 32'h8012_3456);
        run(3, 32'h0000_0102, 1, 0, 32'h0000_ABCD, 5'd0, 0, 1, 0);
        run(1, 32'h0000_0040, 2, 0, 0, 5'd1, 32'h0000_0204, 1, 0);
        run(2, 32'h0000_0101, 2, 0, 0, 5'd7, 0, 2, 32'h1122_3344);

        // reset in the middle of an outstanding access
        step();
        drive(2, 32'h300, 2, 0, 0, 5'd9, 0, 1'b0);
        step();
        valid_ex_i = 1'b0;
        #1;
        chk("rw_req", 32'(mem_req_o), 32'd1);
        step();
        rst_i = 1'b1;
        #1;
        chk("rw_stall", 32'(stall_mem_o), 32'd0);
        chk("rw_valid", 32'(valid_mem_o), 32'd0);
        step();
        rst_i = 1'b0;
        step();
        mem_rvalid_i = 1'b1;
        #1;
        chk("stray_valid", 32'(valid_mem_o), 32'd0);
        chk("stray_we", 32'(rf_we_o), 32'd0);
        chk("stray_req", 32'(mem_req_o), 32'd0);
        chk("stray_stall", 32'(stall_mem_o), 32'd0);
        step();
        mem_rvalid_i = 1'b0;

        // block_mem_i held across completion of a load
        step();
        drive(2, 32'h200, 2, 0, 0, 5'd3, 0, 1'b0);
        step();
        valid_ex_i  = 1'b0;
        block_mem_i = 1'b1;
        #1;
        chk("blk_req", 32'(mem_req_o), 32'd1);
        step();
        chk("blk_wait", 32'(stall_mem_o), 32'd1);
        step();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEAD_BEEF;
        drive(0, 32'h55, 2, 0, 0, 5'd4, 0, 1'b0);
        #1;
        chk("blk_ack_valid", 32'(valid_mem_o), 32'd1);
        chk("blk_ack_data", rf_wdata_o, 32'hDEAD_BEEF);
        step();
        mem_rvalid_i = 1'b0;
        #1;
        chk("blk_once", 32'(valid_mem_o), 32'd0);
        chk("blk_noreq", 32'(mem_req_o), 32'd0);
        chk("blk_nostall", 32'(stall_mem_o), 32'd0);
        step();
        chk("blk_held", 32'(valid_mem_o), 32'd0);
        block_mem_i = 1'b0;
        step();
        valid_ex_i = 1'b0;
        #1;
        chk("blk_rel_valid", 32'(valid_mem_o), 32'd1);
        chk("blk_rel_data", rf_wdata_o, 32'h55);
        block_mem_i   = 1'b1;
        inject_nops_i = 1'b1;
        step();
        chk("blk_wins", 32'(valid_mem_o), 32'd1);
        block_mem_i   = 1'b0;
        inject_nops_i = 1'b0;
        step();
        chk("blk_drain", 32'(valid_mem_o), 32'd0);

        // bubble injection
        drive(0, 32'h77, 2, 0, 0, 5'd8, 0, 1'b1);
        inject_nops_i = 1'b1;
        step();
        inject_nops_i = 1'b0;
        valid_ex_i    = 1'b0;
        #1;
        chk("nop_valid", 32'(valid_mem_o), 32'd0);
        chk("nop_we", 32'(rf_we_o), 32'd0);
        chk("nop_fin", 32'(finish_test_o), 32'd0);

        for (int n = 0; n < 60; n++) begin
            run($urandom_range(0, 3), $urandom, $urandom_range(0, 2),
                1'($urandom_range(0, 1)), $urandom,
                5'($urandom_range(1, 31)), $urandom,
                $urandom_range(1, 4), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
